// File: rtl/instrumented_adder_pkg.sv
// Shared types and constants for the instrumented adder sequencer.
package instrumented_adder_pkg;

   localparam int OPERAND_W = 32;

   // Sequencer phases: operands loaded, ring loop enabled, synchroniser
   // drained, results captured, completion pulse.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_RUN     = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_DONE    = 3'd5
   } state_e;

endpackage

// File: rtl/instrumented_adder_sequencer_edge_sync.sv
// Multi-flop synchroniser for the asynchronous ring-loop output, followed by
// a rising-edge detector on the synchronised level.
module edge_sync
   import instrumented_adder_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   // Shift the async level into the chain; remember the last synchronised level.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   // Synchroniser and edge-detect registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/instrumented_adder_sequencer.sv
// Sequencer that drives an external adder ring, counts synchronised ring
// edges over a programmable window and captures the sum and edge count.
module instrumented_adder_sequencer
   import instrumented_adder_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 32
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 active,
   input  logic                 start,
   input  logic [OPERAND_W-1:0] cfg_a,
   input  logic [OPERAND_W-1:0] cfg_b,
   input  logic [15:0]          window,
   output logic [OPERAND_W-1:0] a_input,
   output logic [OPERAND_W-1:0] b_input,
   output logic                 run_en,
   input  logic                 chain_out,
   input  logic [OPERAND_W-1:0] s_output,
   output logic                 busy,
   output logic                 done,
   output logic [OPERAND_W-1:0] sum_q,
   output logic [CNT_W-1:0]     count_q
);

   localparam logic [15:0]      DRAIN_LAST = 16'(SYNC_STAGES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   state_e                 state_q, state_d;
   logic [15:0]            run_cnt_q, run_cnt_d;
   logic [15:0]            win_q, win_d;
   logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
   logic [OPERAND_W-1:0]   a_q, a_d;
   logic [OPERAND_W-1:0]   b_q, b_d;
   logic [OPERAND_W-1:0]   sum_d;
   logic [CNT_W-1:0]       count_d;
   logic                   rise;

   edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .async_i (chain_out),
      .rise_o  (rise)
   );

   // Next-state, operand/counter updates and capture; abort overrides all.
   always_comb begin
      state_d    = state_q;
      run_cnt_d  = run_cnt_q;
      win_d      = win_q;
      edge_cnt_d = edge_cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      sum_d      = sum_q;
      count_d    = count_q;

      case (state_q)
         ST_IDLE: begin
            if (start && active) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            a_d        = cfg_a;
            b_d        = cfg_b;
            win_d      = window;
            edge_cnt_d = '0;
            run_cnt_d  = '0;
            state_d    = (window == 16'd0) ? ST_DRAIN : ST_RUN;
         end
         ST_RUN: begin
            if (run_cnt_q == 16'(win_q - 16'd1)) begin
               run_cnt_d = '0;
               state_d   = ST_DRAIN;
            end else begin
               run_cnt_d = 16'(run_cnt_q + 16'd1);
            end
         end
         ST_DRAIN: begin
            if (run_cnt_q == DRAIN_LAST) begin
               state_d = ST_CAPTURE;
            end else begin
               run_cnt_d = 16'(run_cnt_q + 16'd1);
            end
         end
         ST_CAPTURE: begin
            sum_d   = s_output;
            count_d = edge_cnt_q;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Edges still in flight after RUN are picked up during DRAIN.
      if ((state_q == ST_RUN || state_q == ST_DRAIN) && rise && (edge_cnt_q != CNT_MAX))
         edge_cnt_d = edge_cnt_q + 1'b1;

      // Deselecting the project abandons the run without touching results.
      if (!active && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         sum_d   = sum_q;
         count_d = count_q;
      end
   end

   // State, counters, operands and captured results.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= ST_IDLE;
         run_cnt_q  <= '0;
         win_q      <= '0;
         edge_cnt_q <= '0;
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         run_cnt_q  <= run_cnt_d;
         win_q      <= win_d;
         edge_cnt_q <= edge_cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sum_q      <= sum_d;
         count_q    <= count_d;
      end
   end

   assign a_input = a_q;
   assign b_input = b_q;
   assign run_en  = (state_q == ST_RUN);
   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_instrumented_adder_sequencer.sv
// Directed bench for instrumented_adder_sequencer: a cycle-indexed model of
// the run schedule checks both a 32-bit and a 4-bit counter instance every
// cycle, and literal expectations pin latency, counts and retained results.
module tb_instrumented_adder_sequencer;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst, active, start, chain;
   logic [31:0] cfg_a, cfg_b;
   logic [15:0] window;

   logic [31:0] a0, b0, s0, sum0, cnt0;
   logic        run0, busy0, done0;
   logic [31:0] a1, b1, s1, sum1;
   logic [3:0]  cnt1;
   logic        run1, busy1, done1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int mode  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External adders
   assign s0 = a0 + b0;
   assign s1 = a1 + b1;

   instrumented_adder_sequencer #(.SYNC_STAGES(S), .CNT_W(32)) dut0 (
      .wb_clk_i(clk), .wb_rst_i(rst), .active(active), .start(start),
      .cfg_a(cfg_a), .cfg_b(cfg_b), .window(window),
      .a_input(a0), .b_input(b0), .run_en(run0), .chain_out(chain),
      .s_output(s0), .busy(busy0), .done(done0), .sum_q(sum0), .count_q(cnt0));

   instrumented_adder_sequencer #(.SYNC_STAGES(S), .CNT_W(4)) dut1 (
      .wb_clk_i(clk), .wb_rst_i(rst), .active(active), .start(start),
      .cfg_a(cfg_a), .cfg_b(cfg_b), .window(window),
      .a_input(a1), .b_input(b1), .run_en(run1), .chain_out(chain),
      .s_output(s1), .busy(busy1), .done(done1), .sum_q(sum1), .count_q(cnt1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance one cycle and drive chain_out: 0 = low, 1 = one rise every
   // 4 cycles, 2 = toggle every cycle (clock/2).
   task automatic step();
      @(posedge clk);
      #1;
      case (mode)
         1:       chain = ((cyc % 4) >= 2);
         2:       chain = ((cyc % 2) == 1);
         default: chain = 1'b0;
      endcase
   endtask

   // ---------------- reference model ----------------
   bit          hist [8192];
   bit          valid = 0;
   int          k = 0;          // 0 idle, 1 load, then run/drain/capture/done
   int          mw = 0;
   int          mc0 = 0, mc1 = 0;
   logic [31:0] ra = 0, rb = 0, esum = 0;
   int          ecnt0 = 0, ecnt1 = 0;

   // A synchronised rise is seen S cycles after the level change reaches the pins.
   function automatic bit rising(input int n);
      if (n < S + 1) return 1'b0;
      return hist[n-S] && !hist[n-S-1];
   endfunction

   always @(negedge clk) begin
      if (cyc < 8192) hist[cyc] = rst ? 1'b0 : chain;
      if (valid) begin
         check("busy0",  32'(busy0), 32'(k != 0));
         check("run0",   32'(run0),  32'(k >= 2 && k <= 1 + mw));
         check("done0",  32'(done0), 32'(k != 0 && k == 3 + mw + S));
         check("a0",     a0, ra);
         check("b0",     b0, rb);
         check("sum0",   sum0, esum);
         check("cnt0",   cnt0, 32'(ecnt0));
         check("busy1",  32'(busy1), 32'(k != 0));
         check("run1",   32'(run1),  32'(k >= 2 && k <= 1 + mw));
         check("done1",  32'(done1), 32'(k != 0 && k == 3 + mw + S));
         check("sum1",   sum1, esum);
         check("cnt1",   32'(cnt1), 32'(ecnt1));
      end
      if (rst) begin
         k = 0; ra = 0; rb = 0; esum = 0; ecnt0 = 0; ecnt1 = 0; mc0 = 0; mc1 = 0;
         valid = 1;
      end else if (k == 0) begin
         if (start && active) k = 1;
      end else begin
         if (k == 1) begin
            ra = cfg_a; rb = cfg_b; mw = int'(window); mc0 = 0; mc1 = 0;
         end
         if (k >= 2 && k <= 1 + mw + S && rising(cyc)) begin
            mc0++;
            if (mc1 < 15) mc1++;
         end
         if (!active) begin
            k = 0;
         end else begin
            if (k == 2 + mw + S) begin
               esum = ra + rb; ecnt0 = mc0; ecnt1 = mc1;
            end
            k = (k == 3 + mw + S) ? 0 : k + 1;
         end
      end
   end

   // Launch one run and wait (bounded) for done; latency counts from the start cycle.
   task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [15:0] w,
                          output int lat, output int run_hi);
      int t;
      step();
      cfg_a = a; cfg_b = b; window = w; start = 1'b1;
      t = cyc;
      step();
      start = 1'b0;
      lat = -1;
      run_hi = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (run0) run_hi++;
         if (done0) begin
            lat = cyc - t;
            break;
         end
         step();
      end
   endtask

   initial begin
      int lat, hi, t, d1, d2;
      bit seen;
      rst = 1'b1; active = 1'b1; start = 1'b0; chain = 1'b0;
      cfg_a = '0; cfg_b = '0; window = '0;

      // Reset then idle
      repeat (3) step();
      rst = 1'b0;
      step();
      @(negedge clk);
      check("rst_busy",  32'(busy0), 32'd0);
      check("rst_done",  32'(done0), 32'd0);
      check("rst_runen", 32'(run0),  32'd0);
      check("rst_sum",   sum0, 32'd0);
      check("rst_count", cnt0, 32'd0);

      // Nominal: 3+4, window 10, one rise every 4 cycles
      mode = 1;
      run_one(32'd3, 32'd4, 16'd10, lat, hi);
      check("nom_latency", 32'(lat), 32'd15);
      check("nom_run_cycles", 32'(hi), 32'd10);
      step();
      @(negedge clk);
      check("nom_sum",   sum0, 32'd7);
      check("nom_count", cnt0, 32'd3);

      // Abort during the 5th RUN cycle
      step();
      cfg_a = 32'd5; cfg_b = 32'd6; window = 16'd10; start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      active = 1'b0;
      step();
      active = 1'b1;
      @(negedge clk);
      check("abort_runen", 32'(run0),  32'd0);
      check("abort_busy",  32'(busy0), 32'd0);
      check("abort_a",     a0, 32'd5);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         @(negedge clk);
         if (done0) seen = 1;
      end
      check("abort_no_done", 32'(seen), 32'd0);
      check("abort_sum",     sum0, 32'd7);
      check("abort_count",   cnt0, 32'd3);

      // window = 0
      mode = 0;
      repeat (6) step();
      run_one(32'd9, 32'd1, 16'd0, lat, hi);
      check("w0_latency", 32'(lat), 32'd5);
      check("w0_run_cycles", 32'(hi), 32'd0);
      step();
      @(negedge clk);
      check("w0_count", cnt0, 32'd0);
      check("w0_sum",   sum0, 32'd10);

      // start held high: back-to-back runs with one IDLE cycle between
      step();
      cfg_a = 32'd1; cfg_b = 32'd1; window = 16'd3; start = 1'b1;
      t = cyc; d1 = -1; d2 = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (d1 >= 0 && cyc == d1 + 1) check("held_idle_gap", 32'(busy0), 32'd0);
         if (done0) begin
            if (d1 < 0) d1 = cyc;
            else d2 = cyc;
         end
         if (d2 >= 0) break;
         step();
      end
      step();
      start = 1'b0;
      check("held_first_done", 32'(d1 - t), 32'd8);
      check("held_period",     32'(d2 - d1), 32'd9);
      repeat (3) step();

      // Reset in mid-run wins over start/active
      step();
      cfg_a = 32'd11; cfg_b = 32'd12; window = 16'd10; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      rst = 1'b1; start = 1'b1;
      step();
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("midrst_busy",  32'(busy0), 32'd0);
      check("midrst_runen", 32'(run0),  32'd0);
      check("midrst_a",     a0, 32'd0);
      check("midrst_sum",   sum0, 32'd0);
      check("midrst_count", cnt0, 32'd0);

      // Saturation: clock/2 toggle over window 100, operand wrap
      mode = 2;
      repeat (4) step();
      run_one(32'hFFFF_FFFF, 32'd2, 16'd100, lat, hi);
      check("sat_latency", 32'(lat), 32'd105);
      check("sat_run_cycles", 32'(hi), 32'd100);
      step();
      @(negedge clk);
      check("sat_count4",  32'(cnt1), 32'd15);
      check("sat_count32", cnt0, 32'd51);
      check("sat_sum",     sum0, 32'd1);
      mode = 0;
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instrumented_adder_sequencer.md
INSTRUMENTED_ADDER_SEQUENCER -- requirements
Module: instrumented_adder_sequencer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops in the chain_out synchroniser (legal range 2..3).
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning the width of the edge counter and of count_q.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port wb_clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port wb_rst_i, input, 1 bit, the synchronous active-high reset.
REQ-006 The block SHALL have port active, input, 1 bit, the project-select enable; when low it aborts any run.
REQ-007 The block SHALL have port start, input, 1 bit, a run request, level-sampled in IDLE.
REQ-008 The block SHALL have port cfg_a, input, 32 bits, operand A.
REQ-009 The block SHALL have port cfg_b, input, 32 bits, operand B.
REQ-010 The block SHALL have port window, input, 16 bits, the number of RUN cycles.
REQ-011 The block SHALL have port a_input, output, 32 bits, registered operand A to the adder.
REQ-012 The block SHALL have port b_input, output, 32 bits, registered operand B to the adder.
REQ-013 The block SHALL have port run_en, output, 1 bit, the enable for the adder ring loop.
REQ-014 The block SHALL have port chain_out, input, 1 bit, the asynchronous loop output from the adder.
REQ-015 The block SHALL have port s_output, input, 32 bits, the adder sum.
REQ-016 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-017 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-018 The block SHALL have port sum_q, output, 32 bits, the captured sum.
REQ-019 The block SHALL have port count_q, output, CNT_W bits, the captured edge count.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD, RUN, DRAIN, CAPTURE and DONE.
REQ-021 In IDLE, when start=1 and active=1, the FSM SHALL go to LOAD; start outside IDLE SHALL be ignored.
REQ-022 In LOAD, the block SHALL register cfg_a/cfg_b into a_input/b_input, clear the edge counter and the run counter, and keep run_en=0.
REQ-023 After LOAD, the FSM SHALL go to RUN; if window=0 it SHALL skip RUN and go directly to DRAIN.
REQ-024 In RUN, run_en SHALL be 1 for exactly window cycles, after which the FSM SHALL go to DRAIN.
REQ-025 chain_out SHALL pass through a SYNC_STAGES-flop synchroniser followed by an edge-detect flop, and the block SHALL increment the counter on each synchronised rising edge during RUN and DRAIN.
REQ-026 The edge counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 DRAIN SHALL last SYNC_STAGES cycles with run_en=0, so that edges still in flight in the synchroniser are counted.
REQ-028 In CAPTURE, the block SHALL latch sum_q<=s_output and count_q<=counter.
REQ-029 In DONE, done SHALL be 1 for one cycle, and the FSM SHALL then go to IDLE.
REQ-030 For start sampled in IDLE at cycle t, done SHALL be high at cycle t+3+window+SYNC_STAGES when window>0, and at cycle t+3+SYNC_STAGES when window=0.
REQ-031 If active=0 in any non-IDLE state, the FSM SHALL go to IDLE on the next edge with run_en=0, no done pulse, and sum_q/count_q unchanged.
REQ-032 sum_q and count_q SHALL hold their values until the next CAPTURE.
REQ-033 a_input and b_input SHALL hold their values until the next LOAD.

Reset
REQ-034 On wb_rst_i=1, the FSM SHALL go to IDLE, and a_input, b_input, sum_q, count_q, the counters and the synchroniser SHALL be 0.
REQ-035 On wb_rst_i=1, run_en, busy and done SHALL be 0.
REQ-036 Reset SHALL take priority over start and active, including in mid-run.

Structure
REQ-037 The FSM state enum and constant OPERAND_W=32 SHALL live in the shared package instrumented_adder_pkg.
REQ-038 The synchroniser plus edge detector SHALL be one sub-module, edge_sync, parameterised by SYNC_STAGES.
REQ-039 The adder itself SHALL stay outside this block.

Verification
REQ-040 Reset then idle: busy=0, done=0, run_en=0, sum_q=0, count_q=0.
REQ-041 Nominal run: cfg_a=3, cfg_b=4, window=10, s_output model=a+b, chain_out toggling every 4 cycles -> run_en high for exactly 10 cycles, done at t+15, sum_q=7, count_q=3 (±0 against the reference model).
REQ-042 window=0 -> run_en never high, done at t+5, count_q=0.
REQ-043 active deasserted during the 5th RUN cycle -> run_en=0 next cycle, no done, previous sum_q/count_q retained.
REQ-044 start held high through a full run -> exactly one run per IDLE visit, and a second run starts the cycle after done.
REQ-045 chain_out = wb_clk_i/2 toggle with CNT_W=4 and window=100 -> count_q saturates at 15.
